// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI4 slave to flat memory port bridge.
// Bus-geometry helpers take the data width so every instance derives its own.
package axi_ram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

    function automatic int unsigned beat_bytes(input int unsigned width);
        return width / 8;
    endfunction

    function automatic int unsigned offset_bits(input int unsigned width);
        return $clog2(width / 8);
    endfunction

    localparam int unsigned DEFAULT_AXI_WIDTH = 128;
    localparam int unsigned BEAT_BYTES        = beat_bytes(DEFAULT_AXI_WIDTH);
    localparam int unsigned OFFSET_BITS       = offset_bits(DEFAULT_AXI_WIDTH);

endpackage

// File: rtl/axi_ram_addr_gen.sv
// Per-channel burst address walker: current address, beat counter and last-beat flag.
// WRAP and reserved bursts are walked as INCR; only FIXED holds the address.
module axi_ram_addr_gen #(
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic                  fixed_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(1) << OFFSET_BITS;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            len_q, len_d;
    logic                  fixed_q, fixed_d;

    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fixed_d = fixed_q;
        if (load_i) begin
            addr_d  = addr_i;
            cnt_d   = '0;
            len_d   = len_i;
            fixed_d = fixed_i;
        end else if (advance_i) begin
            cnt_d = cnt_q + 8'd1;
            if (!fixed_q) begin
                addr_d = addr_q + BEAT_INC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            fixed_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fixed_q <= fixed_d;
        end
    end

    assign mem_addr_o = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign last_o     = (cnt_q == len_q);

endmodule

// File: rtl/axi_ram_port.sv
// AXI4 full slave terminating onto a flat byte-addressed memory port.
// Independent write (zero-latency pass-through) and read (single output register) engines.
module axi_ram_port
    import axi_ram_pkg::*;
#(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_WIDTH-1:0]      s_axi_wdata,
    input  logic [AXI_WIDTH/8-1:0]    s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_WIDTH-1:0]      s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      mem_ren,
    output logic [AXI_ADDR_WIDTH-1:0] mem_raddr,
    input  logic [AXI_WIDTH-1:0]      mem_rdata,
    output logic                      mem_wen,
    output logic [AXI_ADDR_WIDTH-1:0] mem_waddr,
    output logic [AXI_WIDTH-1:0]      mem_wdata,
    output logic [AXI_WIDTH/8-1:0]    mem_wstrb
);

    localparam int         OFF_BITS  = int'(offset_bits(AXI_WIDTH));
    localparam logic [2:0] SIZE_FULL = 3'(OFF_BITS);

    // ---------------- write channel ----------------
    w_state_e                w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0] wid_q, wid_d;
    logic                    werr_q, werr_d;
    logic                    aw_load, w_adv, w_last_beat;

    axi_ram_addr_gen #(.ADDR_WIDTH(AXI_ADDR_WIDTH), .OFFSET_BITS(OFF_BITS)) u_wgen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (aw_load),
        .addr_i     (s_axi_awaddr),
        .len_i      (s_axi_awlen),
        .fixed_i    (s_axi_awburst == BURST_FIXED),
        .advance_i  (w_adv),
        .mem_addr_o (mem_waddr),
        .last_o     (w_last_beat)
    );

    always_comb begin
        w_state_d     = w_state_q;
        wid_d         = wid_q;
        werr_d        = werr_q;
        aw_load       = 1'b0;
        w_adv         = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        mem_wen       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) begin
                    aw_load   = 1'b1;
                    wid_d     = s_axi_awid;
                    werr_d    = s_axi_awburst[1] || (s_axi_awsize != SIZE_FULL);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_wen = 1'b1;
                    w_adv   = 1'b1;
                    // Whichever of wlast / awlen arrives first closes the burst.
                    if (s_axi_wlast || w_last_beat) begin
                        w_state_d = W_RESP;
                        if (s_axi_wlast != w_last_beat) begin
                            werr_d = 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            werr_q    <= werr_d;
        end
    end

    assign s_axi_bid   = wid_q;
    assign s_axi_bresp = werr_q ? RESP_SLVERR : RESP_OKAY;
    assign mem_wdata   = mem_wen ? s_axi_wdata : '0;
    assign mem_wstrb   = mem_wen ? s_axi_wstrb : '0;

    // ---------------- read channel ----------------
    r_state_e                r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;
    logic                    rerr_q, rerr_d;
    logic                    rpend_q, rpend_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rlast_q, rlast_d;
    logic [AXI_WIDTH-1:0]    rdata_q, rdata_d;
    logic                    ar_load, r_adv, r_last_beat;

    axi_ram_addr_gen #(.ADDR_WIDTH(AXI_ADDR_WIDTH), .OFFSET_BITS(OFF_BITS)) u_rgen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ar_load),
        .addr_i     (s_axi_araddr),
        .len_i      (s_axi_arlen),
        .fixed_i    (s_axi_arburst == BURST_FIXED),
        .advance_i  (r_adv),
        .mem_addr_o (mem_raddr),
        .last_o     (r_last_beat)
    );

    always_comb begin
        r_state_d     = r_state_q;
        rid_d         = rid_q;
        rerr_d        = rerr_q;
        rpend_d       = rpend_q;
        rvalid_d      = rvalid_q;
        rlast_d       = rlast_q;
        rdata_d       = rdata_q;
        ar_load       = 1'b0;
        r_adv         = 1'b0;
        s_axi_arready = 1'b0;
        mem_ren       = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) begin
                    ar_load   = 1'b1;
                    rid_d     = s_axi_arid;
                    rerr_d    = s_axi_arburst[1] || (s_axi_arsize != SIZE_FULL);
                    rpend_d   = 1'b1;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (rvalid_q && s_axi_rready) begin
                    rvalid_d = 1'b0;
                end
                // Refill only when the output register is free or draining this cycle.
                if ((!rvalid_q || s_axi_rready) && rpend_q) begin
                    mem_ren  = 1'b1;
                    r_adv    = 1'b1;
                    rdata_d  = mem_rdata;
                    rlast_d  = r_last_beat;
                    rvalid_d = 1'b1;
                    if (r_last_beat) begin
                        rpend_d = 1'b0;
                    end
                end
                if (rvalid_q && s_axi_rready && rlast_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            rerr_q    <= 1'b0;
            rpend_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            rerr_q    <= rerr_d;
            rpend_q   <= rpend_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi_rid    = rid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rerr_q ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast  = rlast_q;
    assign s_axi_rvalid = rvalid_q;

endmodule

// File: tb/tb_axi_ram_port.sv
// Scoreboard bench for axi_ram_port: expected memory writes, B and R beats are queued
// when stimulus is driven and checked as the DUT produces them.
module tb_axi_ram_port;

    localparam int NB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_init;
    logic [5:0]   s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [31:0]  s_axi_awaddr, s_axi_araddr;
    logic [7:0]   s_axi_awlen, s_axi_arlen;
    logic [2:0]   s_axi_awsize, s_axi_arsize;
    logic [1:0]   s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic         s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [127:0] s_axi_wdata, s_axi_rdata, mem_rdata, mem_wdata;
    logic [15:0]  s_axi_wstrb, mem_wstrb;
    logic         s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic         s_axi_bvalid, s_axi_rlast, s_axi_rvalid;
    logic         s_axi_bready = 1'b1;
    logic         s_axi_rready = 1'b1;
    logic         mem_ren, mem_wen;
    logic [31:0]  mem_raddr, mem_waddr;

    typedef struct packed { logic [31:0] addr; logic [127:0] data; logic [15:0] strb; } wexp_t;
    typedef struct packed { logic [5:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [5:0] id; logic [1:0] resp; logic last; logic [127:0] data; } rexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    rexp_t rq[$];

    int n_checks = 0;
    int n_errors = 0;
    bit rrand = 0, brand = 0, wrand = 0;

    logic [7:0] mem     [0:16383];
    logic [7:0] ref_mem [0:16383];

    always #5 clk = ~clk;

    axi_ram_port #(.AXI_WIDTH(128), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 7 + 3) ^ 8'(a >> 8);
    endfunction

    // Memory model: combinational read, byte-strobed commit on the rising edge.
    for (genvar gi = 0; gi < NB; gi++) begin : g_rd
        assign mem_rdata[8*gi +: 8] = mem[{mem_raddr[13:4], 4'(gi)}];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 16384; a++) mem[a] <= init_byte(a);
        end else if (mem_wen) begin
            for (int k = 0; k < NB; k++)
                if (mem_wstrb[k]) mem[{mem_waddr[13:4], 4'(k)}] <= mem_wdata[8*k +: 8];
        end
    end

    always @(posedge clk) begin
        #1;
        s_axi_rready = rrand ? 1'($urandom_range(1, 0)) : 1'b1;
        s_axi_bready = brand ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [1:0] burst, input int i);
        logic [31:0] base;
        base = {addr[31:4], 4'b0};
        return (burst == 2'b00) ? base : base + 32'(i * 16);
    endfunction

    function automatic logic [127:0] ref_word(input logic [31:0] a);
        logic [127:0] w;
        for (int k = 0; k < NB; k++) w[8*k +: 8] = ref_mem[{a[13:4], 4'(k)}];
        return w;
    endfunction

    // Output monitor, sampled on the falling edge.
    logic         r_stall = 1'b0;
    logic [127:0] prev_rdata;
    logic         prev_rlast;
    always @(negedge clk) begin
        wexp_t e; bexp_t b; rexp_t r;
        if (!rst && !mem_init) begin
            if (mem_wen) begin
                if (wq.size() == 0) check("wen_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    check("mem_waddr", mem_waddr, e.addr);
                    check("mem_wdata", mem_wdata, e.data);
                    check("mem_wstrb", mem_wstrb, e.strb);
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    b = bq.pop_front();
                    check("bid", s_axi_bid, b.id);
                    check("bresp", s_axi_bresp, b.resp);
                    $display("B  id=%0h resp=%0d", s_axi_bid, s_axi_bresp);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    r = rq.pop_front();
                    check("rdata", s_axi_rdata, r.data);
                    check("rresp", s_axi_rresp, r.resp);
                    check("rlast", s_axi_rlast, r.last);
                    check("rid", s_axi_rid, r.id);
                    if (r.last) $display("R  id=%0h resp=%0d burst done", s_axi_rid, s_axi_rresp);
                end
            end
            if (r_stall) begin
                check("r_stall_valid", s_axi_rvalid, 1);
                check("r_stall_data", s_axi_rdata, prev_rdata);
                check("r_stall_last", s_axi_rlast, prev_rlast);
            end
        end
        r_stall    = s_axi_rvalid && !s_axi_rready;
        prev_rdata = s_axi_rdata;
        prev_rlast = s_axi_rlast;
    end

    task automatic send_beat(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s, input bit last);
        wexp_t e;
        int t;
        while (wrand && $urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
        e.addr = a; e.data = d; e.strb = s;
        wq.push_back(e);
        for (int k = 0; k < NB; k++) if (s[k]) ref_mem[{a[13:4], 4'(k)}] = d[8*k +: 8];
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_wready && t < 200);
        if (!s_axi_wready) check("w_timeout", 1, 0);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic send_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int t;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_awready && t < 200);
        if (!s_axi_awready) check("aw_timeout", 1, 0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                            input logic [47:0] strb_pat, input logic [127:0] fix_data, input bit chk_resp);
        bexp_t b;
        logic [127:0] d;
        logic [15:0] s;
        b.id   = id;
        b.resp = (burst[1] || size != 3'd4 || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
        bq.push_back(b);
        send_aw(id, addr, len, burst, size);
        for (int i = 0; i < nbeats; i++) begin
            d = (fix_data != '0) ? fix_data : {$urandom(), $urandom(), $urandom(), $urandom()};
            s = (strb_pat != '0 && i < 3) ? strb_pat[16*i +: 16] : 16'hFFFF;
            send_beat(beat_addr(addr, burst, i), d, s, i == nbeats - 1);
        end
        if (chk_resp) begin
            @(negedge clk);
            check("aw_blocked_in_resp", s_axi_awready, 0);
            check("bvalid_after_last", s_axi_bvalid, 1);
            @(negedge clk);
            check("aw_reaccept", s_axi_awready, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input bit chk_stream);
        rexp_t r;
        int t;
        for (int i = 0; i <= int'(len); i++) begin
            r.id   = id;
            r.resp = (burst[1] || size != 3'd4) ? 2'b10 : 2'b00;
            r.last = (i == int'(len));
            r.data = ref_word(beat_addr(addr, burst, i));
            rq.push_back(r);
        end
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_arready && t < 200);
        if (!s_axi_arready) check("ar_timeout", 1, 0);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        if (chk_stream) begin
            @(negedge clk);
            check("r_first_gap", s_axi_rvalid, 0);
            check("r_first_ren", mem_ren, 1);
            for (int i = 0; i <= int'(len); i++) begin
                @(negedge clk);
                check("r_stream", s_axi_rvalid, 1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((wq.size() + bq.size() + rq.size()) != 0 && t < 2000) begin
            @(negedge clk); t++;
        end
        check("drain", 128'(wq.size() + bq.size() + rq.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 16384; a++) ref_mem[a] = init_byte(a);
        rst = 1'b1; mem_init = 1'b1;
        s_axi_awvalid = 0; s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
        s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", s_axi_awready, 1);
        check("rst_arready", s_axi_arready, 1);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_mem_en", {mem_wen, mem_ren}, 0);
        check("rst_rdata_rlast", {s_axi_rdata, s_axi_rlast}, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0;

        // Single beat write then read-back with latency check.
        do_write(6'h05, 32'h100, 8'd0, 2'b01, 3'd4, 1, '0, {16{8'hA5}}, 1'b0);
        wait_idle();
        do_read(6'h06, 32'h100, 8'd0, 2'b01, 3'd4, 1'b1);
        wait_idle();

        // INCR len=3 with random wvalid/rready/bready gaps.
        rrand = 1; brand = 1; wrand = 1;
        do_write(6'h0A, 32'h1000, 8'd3, 2'b01, 3'd4, 4, '0, '0, 1'b0);
        do_read(6'h0B, 32'h1000, 8'd3, 2'b01, 3'd4, 1'b0);
        wait_idle();
        rrand = 0; brand = 0; wrand = 0;
        repeat (2) @(posedge clk); #1;

        // FIXED burst with partial strobes, read back as FIXED.
        do_write(6'h0C, 32'h40, 8'd2, 2'b00, 3'd4, 3, {16'h00F0, 16'hF000, 16'h000F}, '0, 1'b0);
        wait_idle();
        do_read(6'h0D, 32'h40, 8'd2, 2'b00, 3'd4, 1'b0);
        wait_idle();

        // Early wlast, then a clean AW right after the B handshake.
        do_write(6'h2A, 32'h500, 8'd3, 2'b01, 3'd4, 2, '0, '0, 1'b1);
        do_write(6'h2B, 32'h600, 8'd0, 2'b01, 3'd4, 1, '0, '0, 1'b0);
        wait_idle();
        do_read(6'h07, 32'h1000, 8'd3, 2'b10, 3'd4, 1'b0);
        do_write(6'h08, 32'h700, 8'd0, 2'b01, 3'd2, 1, '0, '0, 1'b0);
        wait_idle();

        // Concurrent 16-beat read and write on disjoint regions.
        fork
            do_read(6'h21, 32'h2000, 8'd15, 2'b01, 3'd4, 1'b1);
            do_write(6'h22, 32'h3000, 8'd15, 2'b01, 3'd4, 16, '0, '0, 1'b0);
        join
        wait_idle();
        do_read(6'h23, 32'h3000, 8'd15, 2'b01, 3'd4, 1'b0);
        wait_idle();

        // Reset during beat 2 of an 8-beat write drops the burst silently.
        send_aw(6'h11, 32'h900, 8'd7, 2'b01, 3'd4);
        send_beat(32'h900, {4{32'h1111_2222}}, 16'hFFFF, 1'b0);
        send_beat(32'h910, {4{32'h3333_4444}}, 16'hFFFF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = {4{32'hDEAD_BEEF}}; s_axi_wstrb = 16'hFFFF;
        @(negedge clk);
        check("post_rst_bvalid", s_axi_bvalid, 0);
        check("post_rst_wready", s_axi_wready, 0);
        check("post_rst_awready", s_axi_awready, 1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_wen", mem_wen, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        do_write(6'h12, 32'h900, 8'd7, 2'b01, 3'd4, 8, '0, '0, 1'b0);
        wait_idle();
        do_read(6'h13, 32'h900, 8'd7, 2'b01, 3'd4, 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_ram_port.md
Name: axi_ram_port

Overview:
- AXI4 full slave that terminates the accelerator's AXI master traffic onto a flat byte-addressed memory port: read enable, read address, read data, write enable, write address, write data, write strobe.
- Sits directly downstream of the top-level AXI master (DMA) interface and upstream of the memory model or on-chip RAM.
- Read and write channels are independent and run concurrently.
- Supports FIXED and INCR bursts up to 256 beats, 1 beat per cycle per direction.

Parameters:
- AXI_WIDTH, 128, data bus width in bits; power of 2, ≥32.
- AXI_ADDR_WIDTH, 32, byte address width.
- AXI_ID_WIDTH, 6, transaction ID width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address channel.
- s_axi_awvalid in 1, s_axi_awready out 1  AW handshake.
- s_axi_wdata/wstrb/wlast  in  AXI_WIDTH/AXI_WIDTH/8/1  write data channel.
- s_axi_wvalid in 1, s_axi_wready out 1  W handshake.
- s_axi_bid/bresp  out  ID/2  write response; s_axi_bvalid out 1, s_axi_bready in 1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address channel.
- s_axi_arvalid in 1, s_axi_arready out 1  AR handshake.
- s_axi_rid/rdata/rresp/rlast  out  ID/AXI_WIDTH/2/1  read data channel; s_axi_rvalid out 1, s_axi_rready in 1.
- mem_ren  out  1  memory read enable.
- mem_raddr  out  AXI_ADDR_WIDTH  bus-aligned read byte address.
- mem_rdata  in  AXI_WIDTH  memory read data; combinational, valid in the same cycle as mem_ren.
- mem_wen  out  1  memory write enable; memory commits on the rising edge.
- mem_waddr  out  AXI_ADDR_WIDTH  bus-aligned write byte address.
- mem_wdata  out  AXI_WIDTH  write data.
- mem_wstrb  out  AXI_WIDTH/8  byte enables.

Behaviour:
- Reset values:
  - All valids, mem_ren, mem_wen = 0.
  - awready = arready = 1.
  - wready = 0.
  - bresp, rresp, rlast, IDs, addresses, data = 0.
  - FSMs go to IDLE.
- Reset mid-burst drops the burst silently; no response is issued.
- Address rules:
  - mem addr = current addr with the low log2(AXI_WIDTH/8) bits cleared.
  - INCR: addr += AXI_WIDTH/8 per beat.
  - FIXED: addr is held.
  - WRAP (2'b10) and reserved (2'b11) are executed as INCR and flagged SLVERR.
  - awsize/arsize ≠ log2(AXI_WIDTH/8) executes full-width and flags SLVERR.
  - No 4KB boundary check.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/burst and error flag, then go to W_DATA. awready=0 outside W_IDLE.
  - W_DATA: wready=1. On each W handshake, mem_wen = 1 combinationally, with mem_waddr = current addr and mem_wdata/wstrb = W payload (zero added latency). Beat counter increments.
  - The burst ends on the beat with wlast=1 or the beat whose count == awlen, whichever comes first. If they do not coincide, set SLVERR. Then go to W_RESP.
  - W_RESP: bvalid=1 with bid = latched id and bresp = OKAY (2'b00) or SLVERR (2'b10). Hold until bready; then go to W_IDLE. A new AW is accepted on the cycle after the B handshake.
  - W beats presented while in W_IDLE or W_RESP are not accepted (wready=0).
- Read FSM, states R_IDLE, R_BURST:
  - R_IDLE: arready=1. On AR handshake, latch the request and go to R_BURST.
  - R_BURST uses a single-entry R output register.
  - When the register is empty, or being consumed (rvalid && rready), and beats remain: mem_ren=1, mem_raddr = current addr, and the register loads mem_rdata at the clock edge. rvalid=1 on the next cycle.
  - First rvalid comes 1 cycle after the AR handshake. Sustained 1 beat/cycle with rready=1.
  - rid = latched id; rresp = OKAY or SLVERR on every beat; rlast=1 on beat arlen.
  - After the rlast handshake, go to R_IDLE. arready returns to 1 on the following cycle.
- Backpressure: rdata, rlast and rvalid are held stable while rvalid && !rready. No mem_ren is issued while the register is full and stalled.
- Simultaneous read and write to the same address in one cycle: the read returns pre-write data, because the memory commits on the edge.

Decomposition:
- Package axi_ram_pkg:
  - burst enum: FIXED=0, INCR=1, WRAP=2.
  - resp constants: OKAY=2'b00, SLVERR=2'b10.
  - write and read FSM state enums.
  - BEAT_BYTES and OFFSET_BITS derived from AXI_WIDTH.
- Sub-module axi_ram_addr_gen:
  - Holds the current address and beat counter.
  - Computes the next address (FIXED/INCR), the aligned memory address, and the last-beat flag.
  - Instantiated once per channel.

Test Plan:
- Single write then read: AW addr=0x100, len=0, wdata=0xA5.., wstrb all ones; then AR addr=0x100, len=0. Expect 1 mem_wen at 0x100, bresp=OKAY, rdata = written data, rlast=1, rvalid 1 cycle after AR handshake.
- INCR burst, len=3, addr=0x1000, AXI_WIDTH=128, random wvalid/rready at 50%. Expect mem_waddr sequence 0x1000, 0x1010, 0x1020, 0x1030, readback matches, rlast only on the 4th beat, and no data changes during stalls.
- FIXED burst, len=2, addr=0x40, wstrb=16'h000F then 16'hF000. Expect all beats to address 0x40 and only the strobed bytes written.
- Early wlast on beat 1 with awlen=3. Expect 2 mem_wen, bresp=SLVERR, bid echoed; the next AW accepted after the B handshake. Same check with arburst=WRAP gives rresp=SLVERR on every beat.
- Concurrent 16-beat read of 0x2000 and 16-beat write of 0x3000. Expect both complete independently and the read keeps 1 beat/cycle with rready=1.
- rst=1 asserted for 1 cycle mid write burst (beat 2 of 8). Expect the next cycle to show bvalid=0, wready=0, awready=1, and no further mem_wen; a subsequent clean burst succeeds.
